// File: rtl/vx_rr_stream_arbiter_if.sv
// vx_rr_stream_arbiter_if: request/grant and registered output stream bundle for vx_rr_stream_arbiter
interface vx_rr_stream_arbiter_if #(
  parameter int NUM_REQS = 4,
  parameter int DATAW = 32
);
  localparam int LN = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  logic [NUM_REQS-1:0] valid_in;
  logic [NUM_REQS*DATAW-1:0] data_in;
  logic [NUM_REQS-1:0] ready_in;
  logic valid_out;
  logic [DATAW-1:0] data_out;
  logic [LN-1:0] sel_out;
  logic ready_out;
  modport master (output valid_in, data_in, ready_out, input ready_in, valid_out, data_out, sel_out);
  modport slave (input valid_in, data_in, ready_out, output ready_in, valid_out, data_out, sel_out);
endinterface

// File: rtl/vx_rr_stream_arbiter.sv
// vx_rr_stream_arbiter: round-robin N:1 stream arbiter feeding a registered valid/ready output stage
module vx_rr_stream_arbiter #(
  parameter int NUM_REQS = 4,
  parameter int DATAW = 32,
  localparam int LN = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input logic clk,
  input logic reset,
  vx_rr_stream_arbiter_if.slave bus
);
  logic [LN-1:0] rr_ptr_q, rr_ptr_d, sel_q, sel_d, win_idx;
  logic [LN:0] cand;
  logic [NUM_REQS-1:0] win_onehot;
  logic [DATAW-1:0] data_q, data_d;
  logic valid_q, valid_d, win_any, stage_free, fire;
  always_comb begin
    win_idx = '0;
    win_any = 1'b0;
    cand = '0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + (LN+1)'(k);
      cand = (cand >= (LN+1)'(NUM_REQS)) ? cand - (LN+1)'(NUM_REQS) : cand;
      win_idx = bus.valid_in[cand[LN-1:0]] ? cand[LN-1:0] : win_idx;
      win_any = win_any | bus.valid_in[cand[LN-1:0]];
    end
    win_onehot = win_any ? NUM_REQS'(1) << win_idx : '0;
    stage_free = !valid_q || bus.ready_out;
    fire = win_any && stage_free;
    rr_ptr_d = fire ? ((win_idx == LN'(NUM_REQS - 1)) ? '0 : win_idx + 1'b1) : rr_ptr_q;
    valid_d = fire || (valid_q && !bus.ready_out);
    data_d = fire ? bus.data_in[win_idx*DATAW +: DATAW] : data_q;
    sel_d = fire ? win_idx : sel_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
      valid_q <= 1'b0;
      data_q <= '0;
      sel_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      valid_q <= valid_d;
      data_q <= data_d;
      sel_q <= sel_d;
    end
  end
  assign bus.ready_in = win_onehot & {NUM_REQS{stage_free}};
  assign bus.valid_out = valid_q;
  assign bus.data_out = data_q;
  assign bus.sel_out = sel_q;
endmodule
